// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - Fetch unit bus bundle: imem request/response, decoder stream, redirect
interface ifetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misaligned,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misaligned,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - Instruction fetch: in-order request tracking, drop counter, FIFO buffer
// Optional misaligned-redirect halt enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = 8;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   buf_data [DEPTH];
    logic [63:0]   buf_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, live_cnt;
    logic [DW-1:0] drop_cnt;
    logic [63:0]   fetch_pc, resp_pc;
    logic          misaligned;

    logic          req_fire, resp_take, resp_live, push, pop;
    logic [CW:0]   committed;
    logic [CW-1:0] live_next;
    logic [DW-1:0] drop_next;
    logic [63:0]   redir_tgt;
    logic          redir_bad;

    always_comb begin
        committed = {1'b0, live_cnt} + {1'b0, count};
        // Dropped requests do not hold buffer slots; the MSB guard keeps the drop counter from overflowing.
        bus.imem_req_valid   = rst_n && (committed < DEPTH_C) && !bus.redirect_valid
                               && !misaligned && !drop_cnt[DW-1];
        bus.imem_req_addr    = fetch_pc;
        bus.instr_valid      = (count != '0);
        bus.instr            = buf_data[rd_ptr];
        bus.instr_pc         = buf_pc[rd_ptr];
        bus.fetch_misaligned = misaligned;

        req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        resp_take = bus.imem_resp_valid && ((live_cnt != '0) || (drop_cnt != '0));
        // Dropped requests are always older than live ones, so they drain first.
        resp_live = resp_take && (drop_cnt == '0);
        push      = resp_live && !bus.redirect_valid;
        pop       = bus.instr_valid && bus.instr_ready;
        live_next = live_cnt + CW'(req_fire) - CW'(resp_live);
        drop_next = drop_cnt - DW'(resp_take && !resp_live);
`ifdef IFETCH_ALIGN_CHECK_EN
        redir_tgt = bus.redirect_pc;
        redir_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
        redir_tgt = bus.redirect_pc & ~64'h3;
        redir_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            live_cnt   <= '0;
            drop_cnt   <= '0;
            misaligned <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc   <= redir_tgt;
            resp_pc    <= redir_tgt;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            live_cnt   <= '0;
            drop_cnt   <= drop_next + DW'(live_next);
            misaligned <= redir_bad;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 64'd4;
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 64'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            live_cnt <= live_next;
            drop_cnt <= drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= bus.imem_resp_data;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule
